// File: rtl/instr_issue_ctrl.sv
// rtl/instr_issue_ctrl.sv - program-driven operand issue engine for the ALU datapath
//
// Holds a DEPTH-entry program of {opcode[18:16], a[15:8], b[7:0]} words and
// issues them one at a time to the ALU. The {carry_out, alu_out} result of
// each entry is captured and presented on a one-cycle res_valid strobe.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   prog_we    program write strobe (ignored while busy)
//   prog_addr  program write address
//   prog_data  program word {opcode, a, b}
//   start      begin a run (sampled only in IDLE)
//   prog_len   number of entries to run (0 = none, >DEPTH clamped to DEPTH)
//   a, b       ALU operands
//   opcode     ALU opcode
//   issue      strobe: a/b/opcode are new this cycle
//   alu_out    ALU result
//   carry_out  ALU carry
//   res_valid  strobe: res_data/res_idx valid
//   res_data   captured {carry_out, alu_out}
//   res_idx    program index of the captured result
//   busy       high in every state except IDLE
//   done       strobe at the end of a run

module instr_issue_ctrl #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [18:0]   prog_data,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    output logic [7:0]    a,
    output logic [7:0]    b,
    output logic [2:0]    opcode,
    output logic          issue,
    input  logic [7:0]    alu_out,
    input  logic          carry_out,
    output logic          res_valid,
    output logic [8:0]    res_data,
    output logic [AW-1:0] res_idx,
    output logic          busy,
    output logic          done
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);
    localparam logic [AW:0]   LEN_MAX  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [18:0]   r_mem [DEPTH];
    logic [AW-1:0] r_pc;
    logic [AW:0]   r_len;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_a;
    logic [7:0]    r_b;
    logic [2:0]    r_opcode;
    logic [8:0]    r_res_data;
    logic [AW-1:0] r_res_idx;

    logic [AW:0]   w_len_clamped;
    logic          w_last;
    logic          w_cnt_zero;

    assign w_len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign w_last        = ({1'b0, r_pc} == (r_len - LEN_ONE));
    assign w_cnt_zero    = (r_cnt == '0);

    // Program memory is deliberately left out of reset so a loaded program
    // survives a reset-aborted run.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state == S_IDLE)) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        issue     = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (w_len_clamped != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                w_next = S_ISSUE;
            end
            S_ISSUE: begin
                issue  = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_cnt_zero) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                res_valid = 1'b1;
                w_next    = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The operand registers double as the ALU drive: loading them on the
    // FETCH->ISSUE edge makes a/b/opcode new exactly in the ISSUE cycle,
    // and they hold until the next entry is fetched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_opcode   <= '0;
            r_res_data <= '0;
            r_res_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (w_len_clamped != '0)) begin
                        r_pc  <= '0;
                        r_len <= w_len_clamped;
                    end
                end
                S_FETCH: begin
                    {r_opcode, r_a, r_b} <= r_mem[r_pc];
                end
                S_ISSUE: begin
                    r_cnt <= CNT_INIT;
                end
                S_WAIT: begin
                    if (w_cnt_zero) begin
                        r_res_data <= {carry_out, alu_out};
                        r_res_idx  <= r_pc;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_CAPTURE: begin
                    if (!w_last) begin
                        r_pc <= r_pc + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign a        = r_a;
    assign b        = r_b;
    assign opcode   = r_opcode;
    assign res_data = r_res_data;
    assign res_idx  = r_res_idx;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// tb/tb_instr_issue_ctrl.sv - directed self-checking bench for instr_issue_ctrl

module tb_instr_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [18:0] prog_data;
    logic        start;
    logic [3:0]  prog_len;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  opcode;
    logic        issue;
    logic [7:0]  alu_out;
    logic        carry_out;
    logic        res_valid;
    logic [8:0]  res_data;
    logic [2:0]  res_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int last_done_cyc;

    logic [2:0] exp_op [8];
    logic [8:0] exp_data [8];

    always #5 clk = ~clk;

    instr_issue_ctrl #(.DEPTH(8), .AW(3), .ALU_LAT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .prog_len  (prog_len),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .issue     (issue),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .busy      (busy),
        .done      (done)
    );

    // Reference ALU with one cycle of latency
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = x * y;
        case (op)
            3'd0: alu_f = {1'b0, x} + {1'b0, y};
            3'd1: alu_f = {1'b0, x} - {1'b0, y};
            3'd2: alu_f = {1'b0, x & y};
            3'd3: alu_f = {1'b0, x | y};
            3'd4: alu_f = {1'b0, x ^ y};
            3'd5: alu_f = {|p[15:8], p[7:0]};
            3'd6: alu_f = {1'b0, x >> 1};
            default: alu_f = {(x < y), 7'd0, (x == y)};
        endcase
    endfunction

    always @(posedge clk) begin
        {carry_out, alu_out} <= alu_f(opcode, a, b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_default();
        for (int i = 0; i < 8; i++) begin
            prog_we   = 1'b1;
            prog_addr = 3'(i);
            prog_data = {3'(i), 8'd5, 8'd3};
            step();
        end
        prog_we = 1'b0;
    endtask

    task automatic run_prog(input int len, input int exp_n, input bit disturb, input string tag);
        int  nres;
        int  ndone;
        int  niss;
        bit  fin;
        nres = 0;
        ndone = 0;
        niss = 0;
        fin = 1'b0;
        last_done_cyc = -1;
        prog_len = 4'(len);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (issue) begin
                if (niss < 8) chk({tag, "_op"}, opcode, exp_op[niss]);
                niss++;
            end
            if (res_valid) begin
                if (nres < 8) begin
                    chk({tag, "_idx"}, res_idx, nres);
                    chk({tag, "_data"}, res_data, exp_data[nres]);
                end
                nres++;
                if (disturb && nres == 3) begin
                    start     = 1'b1;
                    prog_len  = 4'd1;
                    prog_we   = 1'b1;
                    prog_addr = 3'd5;
                    prog_data = 19'd0;
                end
            end
            if (done) begin
                ndone++;
                last_done_cyc = cyc;
                fin = 1'b1;
            end
            step();
            start   = 1'b0;
            prog_we = 1'b0;
        end
        chk({tag, "_nres"}, nres, exp_n);
        chk({tag, "_niss"}, niss, exp_n);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int cnt;
        bit hit;
        reset     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        prog_len  = '0;
        repeat (3) step();

        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_issue", issue, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_idx", res_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        reset = 1'b1;
        step();
        load_default();
        for (int i = 0; i < 8; i++) exp_op[i] = 3'(i);
        exp_data[0] = 9'h008;
        exp_data[1] = 9'h002;
        exp_data[2] = 9'h001;
        exp_data[3] = 9'h007;
        exp_data[4] = 9'h006;
        exp_data[5] = 9'h00F;
        exp_data[6] = 9'h002;
        exp_data[7] = 9'h000;

        // Full eight-entry run
        run_prog(8, 8, 1'b0, "run8");

        // Cycle-exact timing: start sampled at edge N
        prog_len = 4'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("tim_n1_issue", issue, 0);
        chk("tim_n1_busy", busy, 1);
        step();
        chk("tim_n2_issue", issue, 1);
        chk("tim_n2_a", a, 5);
        chk("tim_n2_b", b, 3);
        chk("tim_n2_op", opcode, 0);
        step();
        chk("tim_n3_issue", issue, 0);
        chk("tim_n3_rv", res_valid, 0);
        step();
        chk("tim_n4_rv", res_valid, 1);
        chk("tim_n4_data", res_data, 9'h008);
        step();
        chk("tim_n5_rv", res_valid, 0);
        chk("tim_n5_data_hold", res_data, 9'h008);
        step();
        chk("tim_n6_issue", issue, 1);
        chk("tim_n6_op", opcode, 1);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (done) hit = 1'b1;
            step();
        end
        chk("tim_drain_done", hit, 1);

        // Zero-length run: straight to DONE in the cycle after start is sampled
        run_prog(0, 0, 1'b0, "len0");
        chk("len0_done_cyc", last_done_cyc, 0);

        // Length above DEPTH clamps to DEPTH
        run_prog(12, 8, 1'b0, "len12");

        // start and prog_we while busy are both ignored
        run_prog(8, 8, 1'b1, "busy_ign");

        // Reset during WAIT of entry 2
        prog_len = 4'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (issue && opcode == 3'd2) hit = 1'b1;
            step();
        end
        chk("rst5_reach_wait", hit, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst5_a", a, 0);
        chk("rst5_b", b, 0);
        chk("rst5_opcode", opcode, 0);
        chk("rst5_issue", issue, 0);
        chk("rst5_res_valid", res_valid, 0);
        chk("rst5_res_data", res_data, 0);
        chk("rst5_res_idx", res_idx, 0);
        chk("rst5_busy", busy, 0);
        chk("rst5_done", done, 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (res_valid || done || busy) cnt++;
            step();
        end
        chk("rst5_quiet", cnt, 0);
        run_prog(8, 8, 1'b0, "rerun");

        // Carry out of an add
        prog_we   = 1'b1;
        prog_addr = 3'd0;
        prog_data = {3'b000, 8'hFF, 8'h01};
        step();
        prog_we = 1'b0;
        exp_op[0]   = 3'd0;
        exp_data[0] = 9'h100;
        run_prog(1, 1, 1'b0, "carry");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
